// File: rtl/regfile_2r1w_clr.sv
// Two-read, one-write register file with registered reads, write-first bypass and a
// one-entry-per-cycle clear sequencer. Optional parity storage/checking under RF_PARITY_EN.
module regfile_2r1w_clr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_ENABLE,
    input  logic [AW-1:0]    WA,
    input  logic [WIDTH-1:0] Din,
    input  logic [AW-1:0]    RA0,
    input  logic [AW-1:0]    RA1,
    output logic [WIDTH-1:0] Dout0,
    output logic [WIDTH-1:0] Dout1,
`ifdef RF_PARITY_EN
    input  logic             PINJ,
    output logic             PERR0,
    output logic             PERR1,
`endif
    input  logic             CLR_REQ,
    output logic             WR_READY,
    output logic             BUSY,
    output logic             CLR_DONE
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q [2];
    logic [WIDTH-1:0] rd_d [2];
    logic [AW-1:0]    ra [2];
    logic             clearing;
    logic             wr_acc;

    assign ra[0]    = RA0;
    assign ra[1]    = RA1;
    assign clearing = (state_q == StClear);
    assign wr_acc   = WR_ENABLE && !clearing && ({1'b0, WA} < DEPTH_W);

    assign BUSY     = clearing;
    assign WR_READY = !clearing;
    assign CLR_DONE = done_q;
    assign Dout0    = dout_q[0];
    assign Dout1    = dout_q[1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CLR_REQ) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read priority: out of range, then write bypass, then entry being cleared, then array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_d[p] = '0;
            if ({1'b0, ra[p]} < DEPTH_W) begin
                if (wr_acc && (WA == ra[p])) begin
                    rd_d[p] = Din;
                end else if (clearing && (ptr_q == ra[p])) begin
                    rd_d[p] = '0;
                end else begin
                    rd_d[p] = mem_q[ra[p]];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout_q[0] <= '0;
            dout_q[1] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            if (wr_acc) begin
                mem_q[WA] <= Din;
            end
            if (clearing) begin
                mem_q[ptr_q] <= '0;
            end
            dout_q[0] <= rd_d[0];
            dout_q[1] <= rd_d[1];
        end
    end

`ifdef RF_PARITY_EN
    logic par_q [DEPTH];
    logic perr_q [2];
    logic perr_d [2];

    assign PERR0 = perr_q[0];
    assign PERR1 = perr_q[1];

    // Only a genuine array read can flag an error; bypass and cleared reads are clean.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            perr_d[p] = 1'b0;
            if (({1'b0, ra[p]} < DEPTH_W) && !(wr_acc && (WA == ra[p])) &&
                !(clearing && (ptr_q == ra[p]))) begin
                perr_d[p] = par_q[ra[p]] ^ (^mem_q[ra[p]]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
            perr_q[0] <= 1'b0;
            perr_q[1] <= 1'b0;
        end else begin
            if (wr_acc) begin
                par_q[WA] <= (^Din) ^ PINJ;
            end
            if (clearing) begin
                par_q[ptr_q] <= 1'b0;
            end
            perr_q[0] <= perr_d[0];
            perr_q[1] <= perr_d[1];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Randomised and directed bench for regfile_2r1w_clr against an array-based reference model.
module tb_regfile_2r1w_clr;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst, we, clrq;
    logic [3:0] wa, ra0, ra1;
    logic [7:0] din;
    logic [7:0] dout0, dout1;
    logic       wr_ready, busy, clr_done;
`ifdef RF_PARITY_EN
    logic       pinj, perr0, perr1;
`endif

    int n_total = 0;
    int n_bad   = 0;

    regfile_2r1w_clr dut (
        .CLK      (clk),
        .RST      (rst),
        .WR_ENABLE(we),
        .WA       (wa),
        .Din      (din),
        .RA0      (ra0),
        .RA1      (ra1),
        .Dout0    (dout0),
        .Dout1    (dout1),
`ifdef RF_PARITY_EN
        .PINJ     (pinj),
        .PERR0    (perr0),
        .PERR1    (perr1),
`endif
        .CLR_REQ  (clrq),
        .WR_READY (wr_ready),
        .BUSY     (busy),
        .CLR_DONE (clr_done)
    );

    always #5 clk = ~clk;

    // Reference model: plain array plus a count of entries already cleared.
    logic [7:0] m_mem [N];
    bit         m_bad [N];
    bit         m_busy;
    int         m_idx;
    bit         m_done;
    logic [7:0] e0, e1;
    bit         ep0, ep1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_read(input int a, input bit acc, output logic [7:0] d, output bit pe);
        d  = 8'h00;
        pe = 1'b0;
        if (a >= N) return;
        if (acc && int'(wa) == a) d = din;
        else if (m_busy && m_idx == a) d = 8'h00;
        else begin
            d  = m_mem[a];
            pe = m_bad[a];
        end
    endtask

    task automatic model_edge();
        bit acc, done, pin;
        pin = 1'b0;
`ifdef RF_PARITY_EN
        pin = pinj;
`endif
        if (rst) begin
            foreach (m_mem[i]) begin
                m_mem[i] = 8'h00;
                m_bad[i] = 1'b0;
            end
            m_busy = 0; m_idx = 0; m_done = 0;
            e0 = 0; e1 = 0; ep0 = 0; ep1 = 0;
            return;
        end
        acc = we && !m_busy && (int'(wa) < N);
        model_read(int'(ra0), acc, e0, ep0);
        model_read(int'(ra1), acc, e1, ep1);
        done = 0;
        if (acc) begin
            m_mem[wa] = din;
            m_bad[wa] = pin;
        end
        if (m_busy) begin
            m_mem[m_idx] = 8'h00;
            m_bad[m_idx] = 1'b0;
            m_idx++;
            if (m_idx == N) begin
                m_busy = 0;
                done   = 1;
            end
        end else if (clrq) begin
            m_busy = 1;
            m_idx  = 0;
        end
        m_done = done;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("wr_ready", 32'(wr_ready), 32'(!m_busy));
        check_eq("clr_done", 32'(clr_done), 32'(m_done));
        check_eq("dout0", 32'(dout0), 32'(e0));
        check_eq("dout1", 32'(dout1), 32'(e1));
`ifdef RF_PARITY_EN
        check_eq("perr0", 32'(perr0), 32'(ep0));
        check_eq("perr1", 32'(perr1), 32'(ep1));
`endif
    endtask

    int busy_cnt, done_cnt;

    initial begin
        rst = 1; we = 0; clrq = 0; wa = 0; ra0 = 0; ra1 = 0; din = 0;
`ifdef RF_PARITY_EN
        pinj = 0;
`endif
        tick();
        tick();
        rst = 0;
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_dout0", 32'(dout0), 32'h0);

        // Read every address on both ports after reset.
        for (int a = 0; a < N; a++) begin
            ra0 = 4'(a);
            ra1 = 4'(N - 1 - a);
            tick();
            check_eq("reset_read0", 32'(dout0), 32'h0);
            check_eq("reset_read1", 32'(dout1), 32'h0);
        end

        // Two writes then a dual read.
        we = 1; wa = 4'd3;  din = 8'hA5; tick();
        wa = 4'd12; din = 8'h3C; tick();
        we = 0; ra0 = 4'd3; ra1 = 4'd12; tick();
        check_eq("rd_a5", 32'(dout0), 32'hA5);
        check_eq("rd_3c", 32'(dout1), 32'h3C);

        // Write-first bypass on both ports.
        we = 1; wa = 4'd5; din = 8'h77; ra0 = 4'd5; ra1 = 4'd5; tick();
        we = 0;
        check_eq("bypass0", 32'(dout0), 32'h77);
        check_eq("bypass1", 32'(dout1), 32'h77);

        // Fill, clear, and try to write during the clear.
        for (int a = 0; a < N; a++) begin
            we = 1; wa = 4'(a); din = 8'(8'h10 + a); tick();
        end
        we = 0; clrq = 1; tick();
        clrq = 0;
        busy_cnt = 0; done_cnt = 0;
        if (busy) busy_cnt++;
        for (int c = 0; c < 20; c++) begin
            we  = (c < 3);
            wa  = 4'd15; din = 8'hFF;
            ra0 = 4'(c % N); ra1 = 4'd15;
            tick();
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        we = 0;
        check_eq("busy_cycles", 32'(busy_cnt), 32'(N));
        check_eq("done_pulses", 32'(done_cnt), 32'h1);
        ra0 = 4'd15; tick();
        check_eq("e15_cleared", 32'(dout0), 32'h0);

        // Reset in the middle of a clear.
        for (int a = 0; a < N; a++) begin
            we = 1; wa = 4'(a); din = 8'(8'hC0 + a); tick();
        end
        we = 0; clrq = 1; tick();
        clrq = 0;
        for (int c = 0; c < 5; c++) tick();
        rst = 1; tick();
        rst = 0;
        check_eq("rst_mid_busy", 32'(busy), 32'h0);
        check_eq("rst_mid_done", 32'(clr_done), 32'h0);
        for (int a = 0; a < N; a++) begin
            ra0 = 4'(a); ra1 = 4'(a);
            tick();
            check_eq("rst_mid_read", 32'(dout0), 32'h0);
        end

`ifdef RF_PARITY_EN
        we = 1; wa = 4'd2; din = 8'h01; pinj = 1; tick();
        we = 0; pinj = 0; ra0 = 4'd2; tick();
        check_eq("pinj_data", 32'(dout0), 32'h01);
        check_eq("pinj_perr", 32'(perr0), 32'h1);
        we = 1; tick();
        we = 0; tick();
        check_eq("par_clean", 32'(perr0), 32'h0);
`endif

        // Random traffic, with frequent address collisions to exercise bypass and clears.
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            we   = 1'($urandom_range(0, 1));
            wa   = 4'($urandom_range(0, N - 1));
            din  = 8'($urandom);
            clrq = ($urandom_range(0, 39) == 0);
            ra0  = 4'($urandom_range(0, N - 1));
            ra1  = ($urandom_range(0, 3) == 0) ? ra0 : 4'($urandom_range(0, N - 1));
            if ($urandom_range(0, 3) == 0) ra0 = wa;
`ifdef RF_PARITY_EN
            pinj = ($urandom_range(0, 7) == 0);
`endif
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
